// File: rtl/mem_stage_pkg.sv
// ============================================================================
// Module : PipelineReg (package)
// Brief  : Pipeline register bundles and load/store func3 encodings.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package PipelineReg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef struct packed {
        logic [31:0] ALUOutput;
        logic [31:0] rd2;
        logic [2:0]  func3;
        logic        mem_read;
        logic        mem_write;
        logic [4:0]  rd;
        logic        reg_write;
    } MEM_STATE;

    typedef struct packed {
        logic [31:0] result;
        logic [4:0]  rd;
        logic        reg_write;
    } WB_STATE;

endpackage

`default_nettype wire

// File: rtl/mem_stage_align.sv
// ============================================================================
// Module : mem_align
// Brief  : Combinational store-lane/byte-enable generation, load extraction
//          with sign/zero extension, and misalignment detection.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

import PipelineReg::*;

module mem_align (
    input  logic [2:0]  i_st_func3,
    input  logic [1:0]  i_st_off,
    input  logic [31:0] i_st_data,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic        o_misaligned,
    input  logic [2:0]  i_ld_func3,
    input  logic [1:0]  i_ld_off,
    input  logic [31:0] i_ld_word,
    output logic [31:0] o_ld_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        o_be    = 4'b1111;
        o_wdata = i_st_data;
        case (i_st_func3[1:0])
            2'b00: begin
                o_be    = 4'b0001 << i_st_off;
                o_wdata = {4{i_st_data[7:0]}};
            end
            2'b01: begin
                o_be    = 4'b0011 << i_st_off;
                o_wdata = {2{i_st_data[15:0]}};
            end
            default: ;
        endcase
    end

    assign o_misaligned = ((i_st_func3[1:0] == 2'b01) && i_st_off[0])
                       || ((i_st_func3[1:0] == 2'b10) && (i_st_off != 2'b00));

    always_comb begin
        case (i_ld_off)
            2'd0:    w_byte = i_ld_word[7:0];
            2'd1:    w_byte = i_ld_word[15:8];
            2'd2:    w_byte = i_ld_word[23:16];
            default: w_byte = i_ld_word[31:24];
        endcase
        w_half = i_ld_off[1] ? i_ld_word[31:16] : i_ld_word[15:0];
        case (i_ld_func3)
            F3_LB:   o_ld_data = {{24{w_byte[7]}}, w_byte};
            F3_LH:   o_ld_data = {{16{w_half[15]}}, w_half};
            F3_LBU:  o_ld_data = {24'd0, w_byte};
            F3_LHU:  o_ld_data = {16'd0, w_half};
            default: o_ld_data = i_ld_word;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/mem_stage.sv
// ============================================================================
// Module : mem_stage
// Brief  : RV32 memory-access stage: req/gnt/rvalid data port, one access
//          outstanding, registered write-back bundle.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

import PipelineReg::*;

module mem_stage (
    input  logic        i_clk,
    input  logic        i_reset,
    input  MEM_STATE    i_mem_state,
    input  logic        i_valid,
    output logic        o_ready,
    output logic        o_dmem_req,
    output logic        o_dmem_we,
    output logic [31:0] o_dmem_addr,
    output logic [3:0]  o_dmem_be,
    output logic [31:0] o_dmem_wdata,
    input  logic        i_dmem_gnt,
    input  logic        i_dmem_rvalid,
    input  logic [31:0] i_dmem_rdata,
    output WB_STATE     o_wb_state,
    output logic        o_wb_valid,
    output logic        o_misaligned
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic        we_q, we_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] wdata_q, wdata_d;
    logic [2:0]  func3_q, func3_d;
    logic [4:0]  rd_q, rd_d;
    logic        reg_write_q, reg_write_d;
    WB_STATE     wb_q, wb_d;
    logic        wb_valid_q, wb_valid_d;
    logic        misaligned_q, misaligned_d;

    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic        w_misaligned;
    logic [31:0] w_ld_data;

    mem_align u_align (
        .i_st_func3   (i_mem_state.func3),
        .i_st_off     (i_mem_state.ALUOutput[1:0]),
        .i_st_data    (i_mem_state.rd2),
        .o_be         (w_be),
        .o_wdata      (w_wdata),
        .o_misaligned (w_misaligned),
        .i_ld_func3   (func3_q),
        .i_ld_off     (addr_q[1:0]),
        .i_ld_word    (i_dmem_rdata),
        .o_ld_data    (w_ld_data)
    );

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        we_d         = we_q;
        be_d         = be_q;
        wdata_d      = wdata_q;
        func3_d      = func3_q;
        rd_d         = rd_q;
        reg_write_d  = reg_write_q;
        wb_d         = wb_q;
        wb_valid_d   = 1'b0;
        misaligned_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (i_valid) begin
                    if (!i_mem_state.mem_read && !i_mem_state.mem_write) begin
                        wb_d       = '{result: i_mem_state.ALUOutput, rd: i_mem_state.rd,
                                       reg_write: i_mem_state.reg_write};
                        wb_valid_d = 1'b1;
                    end else if (w_misaligned) begin
                        // Dropped access still retires so the pipeline keeps its slot order.
                        wb_d         = '{result: i_mem_state.ALUOutput, rd: i_mem_state.rd,
                                         reg_write: 1'b0};
                        wb_valid_d   = 1'b1;
                        misaligned_d = 1'b1;
                    end else begin
                        addr_d      = i_mem_state.ALUOutput;
                        we_d        = i_mem_state.mem_write;
                        be_d        = w_be;
                        wdata_d     = w_wdata;
                        func3_d     = i_mem_state.func3;
                        rd_d        = i_mem_state.rd;
                        reg_write_d = i_mem_state.reg_write;
                        state_d     = S_REQ;
                    end
                end
            end
            S_REQ: begin
                if (i_dmem_gnt) begin
                    if (we_q) begin
                        wb_d       = '{result: 32'd0, rd: rd_q, reg_write: 1'b0};
                        wb_valid_d = 1'b1;
                        state_d    = S_IDLE;
                    end else if (i_dmem_rvalid) begin
                        wb_d       = '{result: w_ld_data, rd: rd_q, reg_write: reg_write_q};
                        wb_valid_d = 1'b1;
                        state_d    = S_IDLE;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (i_dmem_rvalid) begin
                    wb_d       = '{result: w_ld_data, rd: rd_q, reg_write: reg_write_q};
                    wb_valid_d = 1'b1;
                    state_d    = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q      <= S_IDLE;
            addr_q       <= 32'd0;
            we_q         <= 1'b0;
            be_q         <= 4'd0;
            wdata_q      <= 32'd0;
            func3_q      <= 3'd0;
            rd_q         <= 5'd0;
            reg_write_q  <= 1'b0;
            wb_q         <= '0;
            wb_valid_q   <= 1'b0;
            misaligned_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            we_q         <= we_d;
            be_q         <= be_d;
            wdata_q      <= wdata_d;
            func3_q      <= func3_d;
            rd_q         <= rd_d;
            reg_write_q  <= reg_write_d;
            wb_q         <= wb_d;
            wb_valid_q   <= wb_valid_d;
            misaligned_q <= misaligned_d;
        end
    end

    assign o_ready      = (state_q == S_IDLE);
    assign o_dmem_req   = (state_q == S_REQ);
    assign o_dmem_we    = we_q;
    assign o_dmem_addr  = {addr_q[31:2], 2'b00};
    assign o_dmem_be    = be_q;
    assign o_dmem_wdata = wdata_q;
    assign o_wb_state   = wb_q;
    assign o_wb_valid   = wb_valid_q;
    assign o_misaligned = misaligned_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_stage.sv
// ============================================================================
// Module : tb_mem_stage
// Brief  : Directed self-checking bench for mem_stage.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

import PipelineReg::*;

module tb_mem_stage;

    logic        clk;
    logic        rst_n;
    MEM_STATE    mem_state;
    logic        valid;
    logic        ready;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    WB_STATE     wb_state;
    logic        wb_valid;
    logic        misaligned;

    int n_cmp = 0;
    int n_err = 0;

    mem_stage dut (
        .i_clk         (clk),
        .i_reset       (rst_n),
        .i_mem_state   (mem_state),
        .i_valid       (valid),
        .o_ready       (ready),
        .o_dmem_req    (req),
        .o_dmem_we     (we),
        .o_dmem_addr   (addr),
        .o_dmem_be     (be),
        .o_dmem_wdata  (wdata),
        .i_dmem_gnt    (gnt),
        .i_dmem_rvalid (rvalid),
        .i_dmem_rdata  (rdata),
        .o_wb_state    (wb_state),
        .o_wb_valid    (wb_valid),
        .o_misaligned  (misaligned)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents one instruction for a single accept edge; returns #1 into cycle N+1.
    task automatic issue(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f3,
                         input logic mr, input logic mw, input logic [4:0] rd, input logic rw);
        mem_state = '{ALUOutput: a, rd2: d, func3: f3, mem_read: mr, mem_write: mw,
                      rd: rd, reg_write: rw};
        valid = 1'b1;
        step();
        valid = 1'b0;
    endtask

    // Load with gnt one cycle after accept and rvalid one cycle after that.
    task automatic load_check(input string tag, input logic [31:0] a, input logic [2:0] f3,
                              input logic [31:0] word, input logic [31:0] exp);
        issue(a, 32'd0, f3, 1'b1, 1'b0, 5'd7, 1'b1);
        gnt = 1'b1;
        step();
        gnt    = 1'b0;
        rvalid = 1'b1;
        rdata  = word;
        step();
        rvalid = 1'b0;
        chk({tag, "_valid"}, {31'd0, wb_valid}, 32'd1);
        chk({tag, "_result"}, wb_state.result, exp);
    endtask

    initial begin
        rst_n     = 1'b0;
        mem_state = '0;
        valid     = 1'b0;
        gnt       = 1'b0;
        rvalid    = 1'b0;
        rdata     = 32'd0;
        repeat (3) step();

        chk("rst_ready", {31'd0, ready}, 32'd1);
        chk("rst_req", {31'd0, req}, 32'd0);
        chk("rst_we", {31'd0, we}, 32'd0);
        chk("rst_addr", addr, 32'd0);
        chk("rst_be", {28'd0, be}, 32'd0);
        chk("rst_wdata", wdata, 32'd0);
        chk("rst_wbv", {31'd0, wb_valid}, 32'd0);
        chk("rst_wbs", {31'd0, |wb_state}, 32'd0);
        chk("rst_mis", {31'd0, misaligned}, 32'd0);
        rst_n = 1'b1;
        step();

        // ALU pass-through
        issue(32'h0000_1234, 32'd0, 3'b000, 1'b0, 1'b0, 5'd5, 1'b1);
        chk("alu_valid", {31'd0, wb_valid}, 32'd1);
        chk("alu_result", wb_state.result, 32'h0000_1234);
        chk("alu_rd", {27'd0, wb_state.rd}, 32'd5);
        chk("alu_rw", {31'd0, wb_state.reg_write}, 32'd1);
        chk("alu_ready", {31'd0, ready}, 32'd1);
        step();
        chk("alu_valid_pulse", {31'd0, wb_valid}, 32'd0);

        // SB with two gnt wait cycles
        issue(32'h0000_0103, 32'hAABB_CCDD, F3_LB, 1'b0, 1'b1, 5'd0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            chk("sb_req", {31'd0, req}, 32'd1);
            chk("sb_we", {31'd0, we}, 32'd1);
            chk("sb_be", {28'd0, be}, 32'h8);
            chk("sb_wdata", wdata, 32'hDDDD_DDDD);
            chk("sb_addr", addr, 32'h0000_0100);
            chk("sb_ready", {31'd0, ready}, 32'd0);
            if (i < 2) step();
        end
        gnt = 1'b1;
        step();
        gnt = 1'b0;
        chk("sb_wbv", {31'd0, wb_valid}, 32'd1);
        chk("sb_rw", {31'd0, wb_state.reg_write}, 32'd0);
        chk("sb_req_done", {31'd0, req}, 32'd0);
        chk("sb_ready_done", {31'd0, ready}, 32'd1);

        // SH and SW lanes
        issue(32'h0000_0202, 32'h1234_5678, F3_LH, 1'b0, 1'b1, 5'd0, 1'b0);
        chk("sh_be", {28'd0, be}, 32'hC);
        chk("sh_wdata", wdata, 32'h5678_5678);
        gnt = 1'b1;
        step();
        gnt = 1'b0;
        issue(32'h0000_0010, 32'hCAFE_F00D, F3_LW, 1'b0, 1'b1, 5'd0, 1'b0);
        chk("sw_be", {28'd0, be}, 32'hF);
        chk("sw_wdata", wdata, 32'hCAFE_F00D);
        gnt = 1'b1;
        step();
        gnt = 1'b0;

        // Loads with extension
        load_check("lb", 32'h0000_0202, F3_LB, 32'h0080_0000, 32'hFFFF_FF80);
        load_check("lbu", 32'h0000_0202, F3_LBU, 32'h0080_0000, 32'h0000_0080);
        load_check("lh", 32'h0000_0202, F3_LH, 32'h8001_0000, 32'hFFFF_8001);
        load_check("lhu", 32'h0000_0202, F3_LHU, 32'h8001_0000, 32'h0000_8001);
        chk("ld_rd", {27'd0, wb_state.rd}, 32'd7);

        // Misaligned LH
        issue(32'h0000_0201, 32'd0, F3_LH, 1'b1, 1'b0, 5'd9, 1'b1);
        chk("mis_req", {31'd0, req}, 32'd0);
        chk("mis_pulse", {31'd0, misaligned}, 32'd1);
        chk("mis_wbv", {31'd0, wb_valid}, 32'd1);
        chk("mis_rw", {31'd0, wb_state.reg_write}, 32'd0);
        chk("mis_ready", {31'd0, ready}, 32'd1);
        step();
        chk("mis_pulse_end", {31'd0, misaligned}, 32'd0);

        // LW with gnt and rvalid together
        issue(32'h0000_0300, 32'd0, F3_LW, 1'b1, 1'b0, 5'd3, 1'b1);
        gnt    = 1'b1;
        rvalid = 1'b1;
        rdata  = 32'hDEAD_BEEF;
        step();
        gnt    = 1'b0;
        rvalid = 1'b0;
        chk("lw_wbv", {31'd0, wb_valid}, 32'd1);
        chk("lw_result", wb_state.result, 32'hDEAD_BEEF);
        chk("lw_ready", {31'd0, ready}, 32'd1);
        step();
        chk("lw_no_wait", {31'd0, ready}, 32'd1);
        chk("lw_wbv_end", {31'd0, wb_valid}, 32'd0);

        // Reset while in WAIT
        issue(32'h0000_0400, 32'd0, F3_LW, 1'b1, 1'b0, 5'd4, 1'b1);
        gnt = 1'b1;
        step();
        gnt = 1'b0;
        chk("wait_ready", {31'd0, ready}, 32'd0);
        rst_n = 1'b0;
        #1;
        chk("rstw_req", {31'd0, req}, 32'd0);
        chk("rstw_ready", {31'd0, ready}, 32'd1);
        #1;
        rst_n  = 1'b1;
        rvalid = 1'b1;
        rdata  = 32'h1111_1111;
        step();
        rvalid = 1'b0;
        chk("rstw_no_wb", {31'd0, wb_valid}, 32'd0);
        step();
        chk("rstw_no_wb2", {31'd0, wb_valid}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the RV32IC pipeline. It sits directly downstream of the EX-stage ALU and consumes its `PipelineReg::MEM_STATE` bundle. It performs loads and stores over a req/gnt/rvalid data-memory port, with byte-lane alignment and load sign/zero extension. It stalls EX while an access is outstanding and registers the result into a `PipelineReg::WB_STATE` bundle for write-back.

## Interface
- No parameters; address and data widths are fixed at 32.
- `i_clk`  in  1  pipeline clock, rising edge.
- `i_reset`  in  1  asynchronous, active-low reset.
- `i_mem_state`  in  `PipelineReg::MEM_STATE`  EX result bundle. Fields used:
  - `ALUOutput` (address or result)
  - `rd2` (store data)
  - `func3`
  - `mem_read`, `mem_write`
  - `rd`, `reg_write`
- `i_valid`  in  1  `i_mem_state` holds a valid instruction.
- `o_ready`  out  1  stage accepts `i_mem_state` this cycle; low means stall EX.
- `o_dmem_req`  out  1  memory request.
- `o_dmem_we`  out  1  1 = store, 0 = load.
- `o_dmem_addr`  out  32  word-aligned address, `{addr[31:2], 2'b00}`.
- `o_dmem_be`  out  4  byte enables.
- `o_dmem_wdata`  out  32  lane-shifted store data.
- `i_dmem_gnt`  in  1  request accepted.
- `i_dmem_rvalid`  in  1  load data valid.
- `i_dmem_rdata`  in  32  raw load word.
- `o_wb_state`  out  `PipelineReg::WB_STATE`  fields `{result, rd, reg_write}`.
- `o_wb_valid`  out  1  `o_wb_state` valid for one cycle.
- `o_misaligned`  out  1  one-cycle pulse when a misaligned access is dropped.

## Operation
- FSM states are IDLE, REQ and WAIT.
- Accept rule: an instruction is taken when `i_valid && o_ready`. `o_ready` is 1 only in IDLE.
- IDLE, non-memory op (`mem_read` = `mem_write` = 0): load WB register with `result`=`ALUOutput`, `rd`, `reg_write`; assert `o_wb_valid`; stay in IDLE.
- IDLE, memory op: latch address, store data, `func3`, `rd`, and the op type; go to REQ.
- Misalignment check, done at accept:
  - halfword (`func3[1:0]`=01) with `addr[0]`=1 is misaligned;
  - word (10) with `addr[1:0]`≠0 is misaligned.
  - A misaligned op issues no request, pulses `o_misaligned`, writes WB with `reg_write`=0, and stays in IDLE.
- REQ: hold `o_dmem_req`=1 with stable address, `we`, `be` and `wdata` until `i_dmem_gnt`.
  - Store + gnt: WB entry with `reg_write`=0, go to IDLE.
  - Load + gnt + rvalid in the same cycle: complete the load, go to IDLE.
  - Load + gnt only: go to WAIT.
- WAIT: on `i_dmem_rvalid`, capture the extracted data into WB with `reg_write` from the latched op, go to IDLE.
- Store lanes:
  - SB: `be` = `4'b0001<<addr[1:0]`, `wdata` = `{4{rd2[7:0]}}`.
  - SH: `be` = `4'b0011<<addr[1:0]`, `wdata` = `{2{rd2[15:0]}}`.
  - SW: `be` = 1111, `wdata` = `rd2`.
- Load extract: select the byte/halfword by `addr[1:0]`.
  - LB and LH sign-extend.
  - LBU and LHU zero-extend.
  - LW passes the word through.
- `rd`=x0 with `reg_write`=1 is forwarded unchanged; the register file ignores x0.
- `i_dmem_rvalid` outside WAIT, and outside REQ+gnt, is ignored.

## Timing
- Reset values: state=IDLE, `o_ready`=1, `o_dmem_req`=0, `o_dmem_we`=0, `o_dmem_addr`=0, `o_dmem_be`=0, `o_dmem_wdata`=0, `o_wb_valid`=0, `o_wb_state`=0, `o_misaligned`=0.
- Non-memory op: accepted in cycle N, `o_wb_valid` in N+1.
- Load with zero-wait memory (gnt at N+1, rvalid at N+2): `o_wb_valid` at N+3. Each extra gnt or rvalid wait cycle adds one cycle.
- Store with gnt at N+1: `o_wb_valid` at N+2.
- `o_ready` falls in the cycle after a memory op is accepted and rises in the cycle `o_wb_valid` is asserted. Only one access is ever outstanding.
- Reset mid-operation: asserting `i_reset` at any time asynchronously returns the FSM to IDLE and drops `o_dmem_req`. Any later rvalid is ignored.

## Structure
- Add to package `PipelineReg`:
  - `WB_STATE` struct;
  - any missing `MEM_STATE` fields (`rd2`, `mem_read`, `mem_write`, `rd`, `reg_write`);
  - `func3` width constants LB=000, LH=001, LW=010, LBU=100, LHU=101.
- Sub-module `mem_align`, purely combinational:
  - store lane/byte-enable generation;
  - load extraction and extension;
  - misalignment detect.
- The FSM and registers live in `mem_stage`.

## Test plan
- ALU op, `ALUOutput`=0x0000_1234, `rd`=5, `reg_write`=1 → next cycle `o_wb_valid`=1, `result`=0x1234, `rd`=5; `o_ready` never drops.
- SB addr=0x0000_0103, `rd2`=0xAABB_CCDD → `be`=1000, `wdata`=0xDDDD_DDDD, `addr`=0x100; gnt held low 2 cycles keeps `req` high and the outputs stable.
- LB addr=0x202, rdata=0x0080_0000 → `result`=0xFFFF_FF80. Same case with LBU → 0x0000_0080.
- LH addr=0x201 → no `req`, `o_misaligned` pulse, `o_wb_valid` with `reg_write`=0, `o_ready` stays 1.
- LW addr=0x300 with gnt and rvalid in the same cycle, rdata=0xDEAD_BEEF → `result`=0xDEADBEEF, WAIT never entered.
- Reset asserted in WAIT → `o_dmem_req`=0 and `o_ready`=1 immediately; a subsequent rvalid produces no `o_wb_valid`.
